modn_counter: RTL and testbench
===============================

MODN_COUNTER -- requirements
Module: modn_counter

Interface
REQ-001 SHALL have parameter MOD, default 5: counter modulus (legal 2..2^WIDTH).
REQ-002 SHALL have parameter WIDTH, default 3: state width.
REQ-003 SHALL have parameter EDGE_MODE, default 0: event mode (0 = level, 1 = rising edge).
REQ-004 SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-006 SHALL have port level  input  1: count request.
REQ-007 SHALL have port up_down  input  1: count direction (1 = up, 0 = down).
REQ-008 SHALL have port load  input  1: synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH: load value.
REQ-010 SHALL have port mealy_tick  output  1: combinational terminal-count tick.
REQ-011 SHALL have port moore_tick  output  1: registered terminal-count tick.
REQ-012 SHALL have port state_reg_out  output  WIDTH: current count register.
REQ-013 SHALL have port state_next_out  output  WIDTH: combinational next count.
REQ-014 SHALL have port wrap_count  output  8: saturating wrap counter.

Function
REQ-015 SHALL define evt as follows.
- EDGE_MODE=0: evt = level.
- EDGE_MODE=1: evt = level AND NOT level_d, where level_d is level registered every cycle.
REQ-016 SHALL compute state_next_out in this priority order.
- reset: 0.
- load: min(load_val, MOD-1).
- evt and up_down=1: 0 if state = MOD-1, else state+1.
- evt and up_down=0: MOD-1 if state = 0, else state-1.
- Otherwise: hold state.
REQ-017 SHALL update state_reg_out from state_next_out on every clock edge, with zero additional latency.
REQ-018 SHALL drive mealy_tick = evt AND NOT load AND NOT reset AND the wrap condition, in the same cycle.
- Wrap condition: (up_down=1 and state = MOD-1) or (up_down=0 and state = 0).
REQ-019 SHALL register mealy_tick into moore_tick, so moore_tick is high for exactly the one cycle after each wrap.
REQ-020 SHALL increment wrap_count on each edge where mealy_tick = 1, saturating at 255 (no rollover).
REQ-021 SHALL give load priority over evt when both are asserted together: no count, no tick.
REQ-022 SHALL accept a direction change on any cycle; it takes effect on that cycle's evt.
REQ-023 SHALL never let the state hold a value >= MOD.
REQ-024 SHALL produce no events from level while level is held high in EDGE_MODE=1, other than the first rising edge.

Reset
REQ-025 SHALL, on a clock edge with reset = 1, set state_reg_out = 0, moore_tick = 0 and wrap_count = 0, overriding load and evt.
REQ-026 SHALL keep loading level_d from level during reset, so level held high across reset release generates no edge.
REQ-027 SHALL force mealy_tick = 0 and state_next_out = 0 while reset = 1.
REQ-028 SHALL, if reset is asserted mid-count, return the state to 0 on the next edge and discard any pending wrap.

Verification
REQ-029 Defaults, reset high for 2 cycles, then level = 1, up_down = 1 for 15 cycles.
- state_reg_out SHALL sequence 0,1,2,3,4,0,...
- mealy_tick SHALL be high in each state = 4 cycle; moore_tick SHALL be high in the following state = 0 cycle.
- wrap_count SHALL equal 3 at the end.
REQ-030 From state 0, level = 1, up_down = 0.
- state_next_out SHALL be 4 and mealy_tick SHALL be 1 in the first cycle.
- state_reg_out SHALL sequence 4,3,2,1,0,4.
REQ-031 load = 1 with load_val = 7, MOD = 5, and level = 1 in the same cycle.
- state_reg_out SHALL be 4 on the next edge; mealy_tick SHALL be 0 in the load cycle.
REQ-032 EDGE_MODE = 1: level held high 10 cycles, low 2 cycles, high 1 cycle.
- state_reg_out SHALL advance exactly twice (0 -> 1 -> 2).
- level held high through reset release SHALL produce no count.
REQ-033 Reset asserted for one cycle while state = 3 and level = 1.
- Next edge SHALL give state 0, moore_tick 0, wrap_count 0.
- Counting SHALL resume 1,2,... after reset deasserts.
REQ-034 MOD = 2, WIDTH = 1, level = 1 for 600 cycles.
- wrap_count SHALL reach 255 and stay at 255.
- mealy_tick SHALL continue toggling every other cycle.

Source files
------------

// File: rtl/modn_counter.sv
// ---------------------------------------------------------------------------
// modn_counter
//
// This is an up/down modulo-MOD counter. It has a synchronous load, a
// terminal-count tick in two timings, and a saturating count of wraps.
//
// A count event (evt) comes from the 'level' input:
//   EDGE_MODE = 0 : evt is level itself. The counter steps on every cycle
//                   in which level is high.
//   EDGE_MODE = 1 : evt is the rising edge of level. level_d is a copy of
//                   level taken on every clock edge, including during reset.
//
// Ports
//   clock          : single clock. All state changes on its rising edge.
//   reset          : synchronous, active-high reset.
//   level          : count request.
//   up_down        : count direction (1 = up, 0 = down).
//   load           : synchronous load strobe. It has priority over evt.
//   load_val       : load value. Values >= MOD are clamped to MOD-1.
//   mealy_tick     : combinational tick in the cycle that wraps.
//   moore_tick     : mealy_tick delayed by one register stage.
//   state_reg_out  : current count register. This is the observable state.
//   state_next_out : combinational next count.
//   wrap_count     : number of wraps, saturating at 255.
// ---------------------------------------------------------------------------
module modn_counter #(
  parameter int MOD       = 5,
  parameter int WIDTH     = 3,
  parameter int EDGE_MODE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             level,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             mealy_tick,
  output logic             moore_tick,
  output logic [WIDTH-1:0] state_reg_out,
  output logic [WIDTH-1:0] state_next_out,
  output logic [7:0]       wrap_count
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             level_d;
  logic             evt;
  logic             wrap_cond;
  logic             mealy;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             moore_q;
  logic [7:0]       wrap_q;

  // Event qualification. level_d is only consulted in edge mode.
  always_comb begin
    evt = level;
    if (EDGE_MODE == 1) begin
      evt = level & ~level_d;
    end
  end

  // The counter wraps on this step in the current direction.
  always_comb begin
    wrap_cond = up_down ? (state_q == MAX_VAL) : (state_q == '0);
  end

  // Next-state logic. The priority order is reset, then load, then evt,
  // then hold.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = '0;
    end else if (load) begin
      // Clamp the load so the register never holds a value >= MOD.
      state_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (evt) begin
      if (up_down) begin
        state_d = (state_q == MAX_VAL) ? '0 : state_q + ONE;
      end else begin
        state_d = (state_q == '0) ? MAX_VAL : state_q - ONE;
      end
    end
  end

  // The tick is suppressed by load and by reset, so a pending wrap is dropped.
  always_comb begin
    mealy = evt & ~load & ~reset & wrap_cond;
  end

  always_ff @(posedge clock) begin
    // level_d keeps tracking level during reset. Because of this, a level
    // held high across reset release does not look like a new edge.
    level_d <= level;
    if (reset) begin
      state_q <= '0;
      moore_q <= 1'b0;
      wrap_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      moore_q <= mealy;
      if (mealy && (wrap_q != 8'hFF)) begin
        wrap_q <= wrap_q + 8'd1;
      end
    end
  end

  assign mealy_tick     = mealy;
  assign moore_tick     = moore_q;
  assign state_reg_out  = state_q;
  assign state_next_out = state_d;
  assign wrap_count     = wrap_q;

endmodule

// File: tb/tb_modn_counter.sv
// ---------------------------------------------------------------------------
// tb_modn_counter
//
// Three counter instances share one set of inputs:
//   id 0 : defaults (MOD 5, WIDTH 3, level mode)
//   id 1 : MOD 5, WIDTH 3, edge mode
//   id 2 : MOD 2, WIDTH 1, level mode
// Each phase starts with a reset, so the instances that are not being
// checked can be ignored. Stimulus is driven 1 time unit after posedge.
// Each checked cycle pushes the hand-computed expected outputs for that
// cycle. The monitor pops and compares the selected instance on negedge.
// ---------------------------------------------------------------------------
module tb_modn_counter;

  // ------------------------------------------------------------------ clock/reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       level;
  logic       up_down;
  logic       load;
  logic [2:0] load_val;

  logic       a_mealy, a_moore, b_mealy, b_moore, c_mealy, c_moore;
  logic [2:0] a_reg, a_nxt, b_reg, b_nxt;
  logic [0:0] c_reg, c_nxt;
  logic [7:0] a_wrap, b_wrap, c_wrap;

  modn_counter dut_a (
    .clock(clock), .reset(reset), .level(level), .up_down(up_down),
    .load(load), .load_val(load_val), .mealy_tick(a_mealy),
    .moore_tick(a_moore), .state_reg_out(a_reg), .state_next_out(a_nxt),
    .wrap_count(a_wrap)
  );

  modn_counter #(.MOD(5), .WIDTH(3), .EDGE_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .level(level), .up_down(up_down),
    .load(load), .load_val(load_val), .mealy_tick(b_mealy),
    .moore_tick(b_moore), .state_reg_out(b_reg), .state_next_out(b_nxt),
    .wrap_count(b_wrap)
  );

  modn_counter #(.MOD(2), .WIDTH(1), .EDGE_MODE(0)) dut_c (
    .clock(clock), .reset(reset), .level(level), .up_down(up_down),
    .load(load), .load_val(load_val[0:0]), .mealy_tick(c_mealy),
    .moore_tick(c_moore), .state_reg_out(c_reg), .state_next_out(c_nxt),
    .wrap_count(c_wrap)
  );

  // ------------------------------------------------------------------ scoreboard
  // Packed record: {id[1:0], reg[2:0], nxt[2:0], mealy, moore, wrap[7:0]}
  logic [17:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic cmp(input string name, input int cyc, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  int row = 0;

  // Monitor: compares the instance named in each popped record.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      logic [2:0]  act_reg, act_nxt;
      logic        act_mealy, act_moore;
      logic [7:0]  act_wrap;
      e = exp_q.pop_front();
      case (e[17:16])
        2'd0: begin
          act_reg = a_reg; act_nxt = a_nxt; act_mealy = a_mealy;
          act_moore = a_moore; act_wrap = a_wrap;
        end
        2'd1: begin
          act_reg = b_reg; act_nxt = b_nxt; act_mealy = b_mealy;
          act_moore = b_moore; act_wrap = b_wrap;
        end
        default: begin
          act_reg = {2'b00, c_reg}; act_nxt = {2'b00, c_nxt};
          act_mealy = c_mealy; act_moore = c_moore; act_wrap = c_wrap;
        end
      endcase
      cmp("state_reg",  row, {5'd0, act_reg},   {5'd0, e[15:13]});
      cmp("state_next", row, {5'd0, act_nxt},   {5'd0, e[12:10]});
      cmp("mealy_tick", row, {7'd0, act_mealy}, {7'd0, e[9]});
      cmp("moore_tick", row, {7'd0, act_moore}, {7'd0, e[8]});
      cmp("wrap_count", row, act_wrap,          e[7:0]);
      row++;
    end
  end

  // ------------------------------------------------------------------ driver
  // Applies inputs for one cycle. If chk is set, the task also queues the
  // outputs expected in that cycle, before the next edge.
  task automatic step(input logic rst, input logic lv, input logic ud,
                      input logic ld, input logic [2:0] lval, input bit chk,
                      input logic [1:0] id, input logic [2:0] e_reg,
                      input logic [2:0] e_nxt, input logic e_mealy,
                      input logic e_moore, input logic [7:0] e_wrap);
    reset    = rst;
    level    = lv;
    up_down  = ud;
    load     = ld;
    load_val = lval;
    if (chk) exp_q.push_back({id, e_reg, e_nxt, e_mealy, e_moore, e_wrap});
    @(posedge clock);
    #1;
  endtask

  // Row format: reset, level, up_down, load, load_val, expect reg/nxt/mealy/moore/wrap
  typedef struct packed {
    logic rst, lv, ud, ld;
    logic [2:0] lval;
    logic [2:0] e_reg, e_nxt;
    logic e_mealy, e_moore;
    logic [7:0] e_wrap;
  } vec_t;

  vec_t vec_a[24];
  vec_t vec_b[26];

  initial begin
    // Default instance: counting down from 0, loads, and reset mid-count.
    vec_a = '{
      '{0,1,0,0,3'd0, 3'd0,3'd4,1,1,8'd3},  // down from 0 wraps to 4
      '{0,1,0,0,3'd0, 3'd4,3'd3,0,1,8'd4},
      '{0,1,0,0,3'd0, 3'd3,3'd2,0,0,8'd4},
      '{0,1,0,0,3'd0, 3'd2,3'd1,0,0,8'd4},
      '{0,1,0,0,3'd0, 3'd1,3'd0,0,0,8'd4},
      '{0,1,0,0,3'd0, 3'd0,3'd4,1,0,8'd4},
      '{0,1,0,0,3'd0, 3'd4,3'd3,0,1,8'd5},
      '{0,1,1,1,3'd7, 3'd3,3'd4,0,0,8'd5},  // load 7 clamps to 4, no count
      '{0,0,1,0,3'd0, 3'd4,3'd4,0,0,8'd5},
      '{0,1,1,1,3'd2, 3'd4,3'd2,0,0,8'd5},  // load beats a wrap: no tick
      '{0,0,1,0,3'd0, 3'd2,3'd2,0,0,8'd5},
      '{0,1,1,0,3'd0, 3'd2,3'd3,0,0,8'd5},
      '{1,1,1,0,3'd0, 3'd3,3'd0,0,0,8'd5},  // reset mid-count at state 3
      '{0,1,1,0,3'd0, 3'd0,3'd1,0,0,8'd0},
      '{0,1,1,0,3'd0, 3'd1,3'd2,0,0,8'd0},
      '{0,1,1,0,3'd0, 3'd2,3'd3,0,0,8'd0},
      '{0,1,1,0,3'd0, 3'd3,3'd4,0,0,8'd0},
      '{1,1,1,0,3'd0, 3'd4,3'd0,0,0,8'd0},  // reset drops a pending wrap
      '{0,0,1,0,3'd0, 3'd0,3'd0,0,0,8'd0},
      '{0,1,0,1,3'd1, 3'd0,3'd1,0,0,8'd0},  // load in down mode, no wrap
      '{0,0,0,0,3'd0, 3'd1,3'd1,0,0,8'd0},
      '{0,1,1,0,3'd0, 3'd1,3'd2,0,0,8'd0},  // direction change takes effect now
      '{0,1,0,0,3'd0, 3'd2,3'd1,0,0,8'd0},
      '{0,0,0,0,3'd0, 3'd1,3'd1,0,0,8'd0}
    };
    // Edge-mode instance. The first row holds level high through reset
    // release; the counter must not step. After that, the bench drives
    // low 1, high 10, low 2, high 1, low.
    vec_b[0] = '{0,1,1,0,3'd0, 3'd0,3'd0,0,0,8'd0};
    vec_b[1] = '{0,1,1,0,3'd0, 3'd0,3'd0,0,0,8'd0};
    vec_b[2] = '{0,1,1,0,3'd0, 3'd0,3'd0,0,0,8'd0};
    vec_b[3] = '{0,0,1,0,3'd0, 3'd0,3'd0,0,0,8'd0};
    vec_b[4] = '{0,1,1,0,3'd0, 3'd0,3'd1,0,0,8'd0};
    for (int i = 5; i < 14; i++) vec_b[i] = '{0,1,1,0,3'd0, 3'd1,3'd1,0,0,8'd0};
    vec_b[14] = '{0,0,1,0,3'd0, 3'd1,3'd1,0,0,8'd0};
    vec_b[15] = '{0,0,1,0,3'd0, 3'd1,3'd1,0,0,8'd0};
    vec_b[16] = '{0,1,1,0,3'd0, 3'd1,3'd2,0,0,8'd0};
    vec_b[17] = '{0,0,1,0,3'd0, 3'd2,3'd2,0,0,8'd0};
    // Down edges: 2 -> 1 -> 0 -> wrap to 4 with a tick.
    vec_b[18] = '{0,1,0,0,3'd0, 3'd2,3'd1,0,0,8'd0};
    vec_b[19] = '{0,1,0,0,3'd0, 3'd1,3'd1,0,0,8'd0};
    vec_b[20] = '{0,0,0,0,3'd0, 3'd1,3'd1,0,0,8'd0};
    vec_b[21] = '{0,1,0,0,3'd0, 3'd1,3'd0,0,0,8'd0};
    vec_b[22] = '{0,0,0,0,3'd0, 3'd0,3'd0,0,0,8'd0};
    vec_b[23] = '{0,1,0,0,3'd0, 3'd0,3'd4,1,0,8'd0};
    vec_b[24] = '{0,1,0,0,3'd0, 3'd4,3'd4,0,1,8'd1};
    vec_b[25] = '{0,0,0,0,3'd0, 3'd4,3'd4,0,0,8'd1};
  end

  // ------------------------------------------------------------------ stimulus
  initial begin
    reset = 1'b1; level = 1'b0; up_down = 1'b1; load = 1'b0; load_val = 3'd0;
    #1;

    // Phase A, id 0. Reset is held for 2 cycles; the second cycle has a
    // down-wrap condition, which reset must mask.
    step(1, 0, 1, 0, 3'd0, 0, 2'd0, 3'd0, 3'd0, 0, 0, 8'd0);
    step(1, 1, 0, 0, 3'd0, 1, 2'd0, 3'd0, 3'd0, 0, 0, 8'd0);
    // Up count for 15 cycles: 0,1,2,3,4,0,... with a wrap after each 4.
    for (int i = 0; i < 15; i++)
      step(0, 1, 1, 0, 3'd0, 1, 2'd0, 3'(i % 5), 3'((i + 1) % 5),
           (i % 5) == 4, (i > 0) && ((i % 5) == 0), 8'(i / 5));
    for (int i = 0; i < 24; i++)
      step(vec_a[i].rst, vec_a[i].lv, vec_a[i].ud, vec_a[i].ld, vec_a[i].lval,
           1, 2'd0, vec_a[i].e_reg, vec_a[i].e_nxt, vec_a[i].e_mealy,
           vec_a[i].e_moore, vec_a[i].e_wrap);

    // Phase B, id 1: edge mode. level is held high through reset.
    step(1, 1, 1, 0, 3'd0, 0, 2'd1, 3'd0, 3'd0, 0, 0, 8'd0);
    step(1, 1, 1, 0, 3'd0, 1, 2'd1, 3'd0, 3'd0, 0, 0, 8'd0);
    for (int i = 0; i < 26; i++)
      step(vec_b[i].rst, vec_b[i].lv, vec_b[i].ud, vec_b[i].ld, vec_b[i].lval,
           1, 2'd1, vec_b[i].e_reg, vec_b[i].e_nxt, vec_b[i].e_mealy,
           vec_b[i].e_moore, vec_b[i].e_wrap);

    // Phase C, id 2: MOD 2 for 600 cycles. wrap_count saturates at 255
    // while the tick keeps toggling.
    step(1, 0, 1, 0, 3'd0, 0, 2'd2, 3'd0, 3'd0, 0, 0, 8'd0);
    step(1, 0, 1, 0, 3'd0, 1, 2'd2, 3'd0, 3'd0, 0, 0, 8'd0);
    for (int i = 0; i < 600; i++)
      step(0, 1, 1, 0, 3'd0, 1, 2'd2, 3'(i % 2), 3'((i + 1) % 2),
           (i % 2) == 1, (i > 0) && ((i % 2) == 0),
           (i / 2 > 255) ? 8'd255 : 8'(i / 2));

    // Drain. Every queued expectation must have been consumed.
    step(0, 0, 1, 0, 3'd0, 0, 2'd0, 3'd0, 3'd0, 0, 0, 8'd0);
    @(posedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 pending entries", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
